// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   - funct3 operation codes (RV32M encoding)
//   - FSM state encoding
//   - funct7 value identifying M-extension R-type instructions
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand preparation for the multiply/divide unit.
// Ports:
//   funct3_i    operation select
//   rs1_i/rs2_i raw operands
//   mag_a_o     |rs1| (or rs1 when treated as unsigned)
//   mag_b_o     |rs2| (or rs2 when treated as unsigned)
//   neg_res_o   final result must be negated (two's complement)
//   fast_hit_o  divide-by-zero or signed overflow: no iteration needed
//   fast_val_o  result for the fast-path cases
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] mag_a_o,
  output logic [XLEN-1:0] mag_b_o,
  output logic            neg_res_o,
  output logic            fast_hit_o,
  output logic [XLEN-1:0] fast_val_o
);

  logic is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
  logic div_zero, div_ovf;

  assign is_div = funct3_i[2];
  assign is_rem = funct3_i[2] & funct3_i[1];

  // DIV/REM have funct3[0]=0 and are signed; MULH signs both, MULHSU only rs1.
  // MUL yields the same low half either way, so it is handled unsigned.
  assign a_signed = is_div ? ~funct3_i[0]
                           : ((funct3_i == F3_MULH) || (funct3_i == F3_MULHSU));
  assign b_signed = is_div ? ~funct3_i[0] : (funct3_i == F3_MULH);

  assign a_neg = a_signed & rs1_i[XLEN-1];
  assign b_neg = b_signed & rs2_i[XLEN-1];

  assign mag_a_o = a_neg ? -rs1_i : rs1_i;
  assign mag_b_o = b_neg ? -rs2_i : rs2_i;

  // Remainder takes the dividend's sign; products and quotients the XOR.
  assign neg_res_o = is_rem ? a_neg : (a_neg ^ b_neg);

  assign div_zero = is_div & (rs2_i == '0);
  assign div_ovf  = is_div & a_signed & (rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                  & (rs2_i == '1);

  assign fast_hit_o = div_zero | div_ovf;

  always_comb begin
    fast_val_o = '0;
    if (div_zero) begin
      fast_val_o = is_rem ? rs1_i : '1;
    end else if (div_ovf) begin
      fast_val_o = is_rem ? '0 : rs1_i;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, kill       issue request / abort of the in-flight operation
//   funct3            operation select
//   rs1_val, rs2_val  forwarded operands
//   busy              stall request (combinational)
//   done              one-cycle pulse, result valid for writeback
//   result            registered final result
//   dbg_state         current FSM state
// Handshake: an operation is accepted on an edge where start=1, kill=0 and
// the FSM is IDLE; done pulses exactly once per accepted, non-killed
// operation; busy covers the whole interval from issue until done.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output state_e          dbg_state
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [XLEN-1:0]   b_q;
  // Multiply: {high, low} product accumulator, multiplier shifted out of
  // the bottom. Divide: low half holds the dividend/quotient shift register.
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic [XLEN-1:0] mag_a, mag_b, fast_val;
  logic            neg_res, fast_hit;

  muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
    .funct3_i   (funct3),
    .rs1_i      (rs1_val),
    .rs2_i      (rs2_val),
    .mag_a_o    (mag_a),
    .mag_b_o    (mag_b),
    .neg_res_o  (neg_res),
    .fast_hit_o (fast_hit),
    .fast_val_o (fast_val)
  );

  // One shift-add step.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc_d;
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
  assign mul_acc_d = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                              : {1'b0, acc_q[2*XLEN-1:1]};

  // One restoring-division step on an XLEN+1 bit partial remainder.
  // The restored remainder is always below the divisor, so it fits XLEN bits.
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_rem_d, div_q_d;
  assign div_shift = {rem_q, acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[XLEN];
  assign div_rem_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_q_d   = {acc_q[XLEN-2:0], div_ge};

  // Sign fix and selection, applied to the values of the last iteration.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;
  assign prod_fix = neg_q ? -mul_acc_d : mul_acc_d;
  assign quo_fix  = neg_q ? -div_q_d : div_q_d;
  assign rem_fix  = neg_q ? -div_rem_d : div_rem_d;

  always_comb begin
    final_res = prod_fix[2*XLEN-1:XLEN];
    if (f3_q[2]) begin
      final_res = f3_q[1] ? rem_fix : quo_fix;
    end else if (f3_q == F3_MUL) begin
      final_res = prod_fix[XLEN-1:0];
    end
  end

  logic last_iter;
  assign last_iter = (cnt_q == CNT_W'(XLEN-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !kill) begin
            f3_q  <= funct3;
            neg_q <= neg_res;
            b_q   <= mag_b;
            acc_q <= {{XLEN{1'b0}}, mag_a};
            rem_q <= '0;
            cnt_q <= '0;
            if (fast_hit) begin
              result_q <= fast_val;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (kill) begin
            state_q <= ST_IDLE;
          end else begin
            if (f3_q[2]) begin
              acc_q <= {acc_q[2*XLEN-1:XLEN], div_q_d};
              rem_q <= div_rem_d;
            end else begin
              acc_q <= mul_acc_d;
            end
            if (last_iter) begin
              result_q <= final_res;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (start & ~kill & (state_q == ST_IDLE)) | (state_q != ST_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic        busy, done;
  logic [31:0] result;
  state_e      dbg_state;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_exp = 32'h0;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .kill      (kill),
    .funct3    (funct3),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference model using wide signed/unsigned arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = 64'h0;
    case (f3)
      F3_MUL:    begin r = sa * sb; p = r; return p[31:0]; end
      F3_MULH:   begin r = sa * sb; p = r; return p[63:32]; end
      F3_MULHSU: begin r = sa * ub; p = r; return p[63:32]; end
      F3_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      F3_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        r = sa / sb; p = r; return p[31:0];
      end
      F3_DIVU: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        r = ua / ub; p = r; return p[31:0];
      end
      F3_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        r = sa % sb; p = r; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        r = ua % ub; p = r; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 32'h0 ||
                     (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Driver: present start for one cycle; busy must rise in that same cycle.
  // Returns at E0 + 1.
  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f3; rs1_val = a; rs2_val = b; start = 1'b1;
    #1 check("busy_on_issue", busy, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    exp_q.push_back(exp);
    drive_start(f3, a, b);
  endtask

  // Waits for done (bounded), checks latency, scoreboard result, pulse width.
  // poke_cycle >= 0 presents a foreign start while the unit is busy.
  task automatic wait_done(input string tag, input int exp_lat, input int poke_cycle);
    int          n;
    logic [31:0] e;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      check({tag, "_busy"}, busy, 1'b1);
      if (n == poke_cycle) begin
        start = 1'b1; funct3 = F3_MULHU; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1234_5678;
      end
      @(posedge clk);
      #1 start = 1'b0;
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_latency"}, n, exp_lat);
    if (done === 1'b1) begin
      check({tag, "_sb_depth"}, exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_exp = e;
        check({tag, "_result"}, result, e);
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_done_pulse_end"}, done, 1'b0);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_result_hold"}, result, last_exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    issue(f3, a, b, exp);
    wait_done(tag, is_fast(f3, a, b) ? 0 : 32, -1);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'b0; rs1_val = 32'h0; rs2_val = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 32'h0);
    @(negedge clk) rst = 1'b0;

    // Directed multiply cases
    run_op("mul_7_m3",     F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulhu_ff_ff",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulh_ff_ff",   F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("mulhsu_ff_2",  F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);

    // Directed divide cases
    run_op("div_m7_2",     F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op("rem_m7_2",     F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op("divu_100_7",   F3_DIVU,   32'd100,       32'd7,         32'd14);
    run_op("remu_100_7",   F3_REMU,   32'd100,       32'd7,         32'd2);

    // Fast paths
    run_op("fast_divu_z",  F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF);
    run_op("fast_rem_z",   F3_REM,    32'd5,         32'd0,         32'd5);
    run_op("fast_div_ovf", F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("fast_rem_ovf", F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_op("fast_div_z",   F3_DIV,    32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF);
    run_op("fast_remu_z",  F3_REMU,   32'h1234_5678, 32'd0,         32'h1234_5678);

    // Kill 10 cycles into a DIV: back to IDLE, no done, result untouched
    drive_start(F3_DIV, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk) kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill_state", dbg_state, ST_IDLE);
    check("kill_busy", busy, 1'b0);
    check("kill_done", done, 1'b0);
    check("kill_result", result, last_exp);
    run_op("after_kill_div", F3_DIV, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3);

    // start together with kill in IDLE is not accepted
    @(negedge clk);
    funct3 = F3_MUL; rs1_val = 32'd9; rs2_val = 32'd9; start = 1'b1; kill = 1'b1;
    #1 check("startkill_busy", busy, 1'b0);
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    check("startkill_state", dbg_state, ST_IDLE);
    check("startkill_done", done, 1'b0);

    // Reset mid-MUL
    drive_start(F3_MUL, 32'd12345, 32'd678);
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_result", result, 32'h0);
    check("midrst_done", done, 1'b0);
    check("midrst_busy", busy, 1'b0);
    last_exp = 32'h0;

    // A start pulse while busy is ignored; the original operands complete
    issue(F3_MUL, 32'd12345, 32'd678, model(F3_MUL, 32'd12345, 32'd678));
    wait_done("busy_start_ignored", 32, 5);

    // Random operations through the reference model
    for (int i = 0; i < 12; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      issue(rf3, ra, rb, model(rf3, ra, rb));
      wait_done("rand", is_fast(rf3, ra, rb) ? 0 : 32, -1);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
